ps2_kbd_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver. It replaces the bare keyboard front end with frame checking, scan-code prefix decoding and a read-side FIFO. It deserialises 11-bit PS/2 frames, folds the 0xE0 (extended) and 0xF0 (break) prefixes into flags, and queues one 10-bit key event per key action. Consumers in the clk domain (segment display, vmem text writer) pop events with a simple ready/rd_en handshake.

---
 rtl/ps2_kbd_fifo.sv | 188 ++++++++++++++++++
 tb/tb_ps2_kbd_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_fifo.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: synchronised frame decode, E0/F0 prefix folding,
// and a first-word fall-through event FIFO for clk-domain consumers.
module ps2_kbd_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          clr_ovf,
  output logic [9:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [7:0]                    err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  logic [SYNC_STAGES-1:0] cs;
  logic [SYNC_STAGES-1:0] ds;
  logic                   fe;
  logic                   din;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        par_ok;
  logic [WW-1:0] wd;
  logic        timeout;
  logic        ext;
  logic        brk;

  logic        err_evt;
  logic        push;
  logic        set_ext;
  logic        set_brk;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [9:0]    hold;
  logic          full;
  logic          pop;
  logic          wr;
  logic          ovf_set;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs <= '1;
      ds <= '1;
    end else begin
      cs <= {cs[SYNC_STAGES-2:0], ps2_clk};
      ds <= {ds[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign fe  = cs[SYNC_STAGES-1] & ~cs[SYNC_STAGES-2];
  assign din = ds[SYNC_STAGES-1];

  assign timeout = (state != IDLE) && !fe &&
                   (wd == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (fe && !din) state_nxt = DATA;
      DATA: begin
        if (timeout)                    state_nxt = IDLE;
        else if (fe && bit_idx == 3'd7) state_nxt = PARITY;
      end
      PARITY: begin
        if (timeout) state_nxt = IDLE;
        else if (fe) state_nxt = STOP;
      end
      STOP:   if (timeout || fe) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    err_evt = 1'b0;
    push    = 1'b0;
    set_ext = 1'b0;
    set_brk = 1'b0;
    if (timeout) begin
      err_evt = 1'b1;
    end else if (fe) begin
      unique case (state)
        IDLE: err_evt = din;
        STOP: begin
          if (!(par_ok && din))  err_evt = 1'b1;
          else if (shift == 8'hE0) set_ext = 1'b1;
          else if (shift == 8'hF0) set_brk = 1'b1;
          else                     push    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift   <= '0;
      bit_idx <= '0;
      par_ok  <= 1'b0;
      wd      <= '0;
      ext     <= 1'b0;
      brk     <= 1'b0;
    end else begin
      if (state == IDLE || fe) wd <= '0;
      else                     wd <= wd + 1'b1;
      if (state == IDLE) bit_idx <= '0;
      else if (state == DATA && fe) begin
        shift   <= {din, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == PARITY && fe) par_ok <= ^shift ^ din;
      if (set_ext) ext <= 1'b1;
      if (set_brk) brk <= 1'b1;
      if (push) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= err_evt;
      if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign ready   = (cnt != '0);
  assign pop     = rd_en && ready;
  assign wr      = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= {brk, ext, shift};
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (wr && !pop)      cnt <= cnt + 1'b1;
      else if (!wr && pop) cnt <= cnt - 1'b1;
      if (ready) hold <= mem[rp];
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign data  = ready ? mem[rp] : hold;
  assign count = cnt;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
`timescale 1ns/1ps
// Directed bench for ps2_kbd_fifo: frames, prefixes, errors,
// FIFO fill/overflow, simultaneous push/pop, timeout and mid-frame reset.
module tb_ps2_kbd_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic       clr_ovf;
  logic [9:0] data;
  logic       ready;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;
  logic [7:0] err_cnt;

  int vec  = 0;
  int miss = 0;
  int fe_seen = 0;

  ps2_kbd_fifo #(
    .FIFO_DEPTH(8),
    .SYNC_STAGES(3),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rd_en(rd_en),
    .clr_ovf(clr_ovf),
    .data(data),
    .ready(ready),
    .count(count),
    .overflow(overflow),
    .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_seen++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: sim did not finish, want finish");
    $fatal(1);
  end

  // One PS/2 bit; optional rd_en on the edge where the frame completes.
  task automatic send_bit(input logic b, input logic pop_at_edge);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    if (pop_at_edge) rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par_inv,
                           input logic stop_val, input logic pop_at_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(~^b ^ par_inv, 1'b0);
    send_bit(stop_val, pop_at_stop);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop1();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    rd_en = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (data !== 10'h000) begin miss++; $display("FAIL rst_data: got %h want 000", data); end
    vec++; if (ready !== 1'b0) begin miss++; $display("FAIL rst_ready: got %b want 0", ready); end
    vec++; if (count !== 4'd0) begin miss++; $display("FAIL rst_count: got %0d want 0", count); end
    vec++; if (overflow !== 1'b0) begin miss++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    vec++; if (frame_err !== 1'b0) begin miss++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
    vec++; if (err_cnt !== 8'd0) begin miss++; $display("FAIL rst_errcnt: got %0d want 0", err_cnt); end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    send_byte(8'h1C, 1'b0, 1'b1, 1'b0);
    vec++; if (ready !== 1'b1) begin miss++; $display("FAIL single_ready: got %b want 1", ready); end
    vec++; if (data !== 10'h01C) begin miss++; $display("FAIL single_data: got %h want 01c", data); end
    vec++; if (count !== 4'd1) begin miss++; $display("FAIL single_count: got %0d want 1", count); end
    pop1();
    vec++; if (ready !== 1'b0) begin miss++; $display("FAIL single_pop_ready: got %b want 0", ready); end
    vec++; if (count !== 4'd0) begin miss++; $display("FAIL single_pop_count: got %0d want 0", count); end
    vec++; if (data !== 10'h01C) begin miss++; $display("FAIL single_hold: got %h want 01c", data); end
  endtask

  task automatic test_prefix();
    send_byte(8'hE0, 1'b0, 1'b1, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b1, 1'b0);
    vec++; if (count !== 4'd0) begin miss++; $display("FAIL prefix_nopush: got %0d want 0", count); end
    send_byte(8'h75, 1'b0, 1'b1, 1'b0);
    vec++; if (count !== 4'd1) begin miss++; $display("FAIL prefix_count: got %0d want 1", count); end
    vec++; if (data !== 10'h375) begin miss++; $display("FAIL prefix_data: got %h want 375", data); end
    pop1();
    send_byte(8'h75, 1'b0, 1'b1, 1'b0);
    vec++; if (data !== 10'h075) begin miss++; $display("FAIL prefix_clear: got %h want 075", data); end
    pop1();
  endtask

  task automatic test_errors();
    fe_seen = 0;
    send_byte(8'h1C, 1'b1, 1'b1, 1'b0);
    vec++; if (fe_seen !== 1) begin miss++; $display("FAIL par_pulse: got %0d want 1", fe_seen); end
    vec++; if (err_cnt !== 8'd1) begin miss++; $display("FAIL par_errcnt: got %0d want 1", err_cnt); end
    vec++; if (ready !== 1'b0) begin miss++; $display("FAIL par_ready: got %b want 0", ready); end
    send_byte(8'h1C, 1'b0, 1'b1, 1'b0);
    vec++; if (data !== 10'h01C) begin miss++; $display("FAIL par_recover: got %h want 01c", data); end
    pop1();
    fe_seen = 0;
    send_byte(8'h22, 1'b0, 1'b0, 1'b0);
    vec++; if (fe_seen !== 1) begin miss++; $display("FAIL stop_pulse: got %0d want 1", fe_seen); end
    vec++; if (err_cnt !== 8'd2) begin miss++; $display("FAIL stop_errcnt: got %0d want 2", err_cnt); end
    vec++; if (count !== 4'd0) begin miss++; $display("FAIL stop_count: got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    logic [9:0] exp_q [$];
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0, 1'b1, 1'b0);
    vec++; if (count !== 4'd8) begin miss++; $display("FAIL ovf_count: got %0d want 8", count); end
    vec++; if (overflow !== 1'b1) begin miss++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    vec++; if (data !== 10'h001) begin miss++; $display("FAIL ovf_head: got %h want 001", data); end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    vec++; if (overflow !== 1'b0) begin miss++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    send_byte(8'h0A, 1'b0, 1'b1, 1'b1);
    vec++; if (overflow !== 1'b0) begin miss++; $display("FAIL pushpop_ovf: got %b want 0", overflow); end
    vec++; if (count !== 4'd8) begin miss++; $display("FAIL pushpop_count: got %0d want 8", count); end
    for (int i = 2; i <= 8; i++) exp_q.push_back(10'(i));
    exp_q.push_back(10'h00A);
    foreach (exp_q[i]) begin
      vec++;
      if (data !== exp_q[i]) begin
        miss++; $display("FAIL drain_%0d: got %h want %h", i, data, exp_q[i]);
      end
      pop1();
    end
    vec++; if (ready !== 1'b0) begin miss++; $display("FAIL drain_empty: got %b want 0", ready); end
  endtask

  task automatic test_timeout();
    fe_seen = 0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (100) @(negedge clk);
    vec++; if (fe_seen !== 1) begin miss++; $display("FAIL tmo_pulse: got %0d want 1", fe_seen); end
    vec++; if (err_cnt !== 8'd3) begin miss++; $display("FAIL tmo_errcnt: got %0d want 3", err_cnt); end
    send_byte(8'h29, 1'b0, 1'b1, 1'b0);
    vec++; if (data !== 10'h029) begin miss++; $display("FAIL tmo_next: got %h want 029", data); end
    vec++; if (count !== 4'd1) begin miss++; $display("FAIL tmo_count: got %0d want 1", count); end
    pop1();
  endtask

  task automatic test_reset_mid();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    resetn = 1'b0;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    fe_seen = 0;
    repeat (100) @(negedge clk);
    vec++; if (count !== 4'd0) begin miss++; $display("FAIL rmid_count: got %0d want 0", count); end
    vec++; if (fe_seen !== 0) begin miss++; $display("FAIL rmid_pulse: got %0d want 0", fe_seen); end
    vec++; if (err_cnt !== 8'd0) begin miss++; $display("FAIL rmid_errcnt: got %0d want 0", err_cnt); end
    send_byte(8'h29, 1'b0, 1'b1, 1'b0);
    vec++; if (data !== 10'h029) begin miss++; $display("FAIL rmid_next: got %h want 029", data); end
    vec++; if (fe_seen !== 0) begin miss++; $display("FAIL rmid_clean: got %0d want 0", fe_seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_errors();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
